load_store_unit: RTL and testbench

Sits between the pipeline MEM stage and the byte-addressed `data_mem`. It translates RISC-V loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW, selected by funct3) into whole-word `data_mem` accesses. `data_mem` always reads and writes 4 bytes at A..A+3, so sub-word stores are done as a registered read-modify-write. This keeps `data_mem`'s combinational read path out of its write path. One access is outstanding at a time; the pipeline stalls on `req_ready`.

---
 rtl/load_store_unit.sv | 124 ++++++++++++
 tb/tb_load_store_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RISC-V load/store unit: maps LB/LH/LW/LBU/LHU/SB/SH/SW onto whole-word data_mem
// accesses, doing sub-word stores as a registered read-modify-write.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] dm_A,
    output logic [DATA_WIDTH-1:0] dm_WD,
    output logic                  dm_WE,
    input  logic [DATA_WIDTH-1:0] dm_RD
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  write_q, write_d;
    logic                  accept;
    logic                  storeOk;

    // Gating with rst_n keeps the requester stalled while reset is held.
    assign req_ready = rst_n && (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign storeOk   = (req_funct3[2] == 1'b0) && (req_funct3[1:0] != 2'b11);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rd_q     <= '0;
            wdata_q  <= '0;
            addr_q   <= '0;
            funct3_q <= '0;
            write_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            wdata_q  <= wdata_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            write_q  <= write_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        wdata_d  = wdata_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        write_d  = write_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rd_d     = dm_RD;
                    wdata_d  = req_wdata;
                    addr_d   = req_addr;
                    funct3_d = req_funct3;
                    write_d  = req_write;
                    // Bad-width stores skip WRITE so data_mem is never touched.
                    state_d  = (req_write && storeOk) ? WRITE : RESP;
                end
            end
            WRITE:   state_d = IDLE;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dm_A      = addr_q;
        dm_WE     = 1'b0;
        dm_WD     = '0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        case (state_q)
            IDLE: dm_A = req_addr;
            WRITE: begin
                dm_WE     = 1'b1;
                rsp_valid = 1'b1;
                case (funct3_q[1:0])
                    2'b00:   dm_WD = {rd_q[DATA_WIDTH-1:8], wdata_q[7:0]};
                    2'b01:   dm_WD = {rd_q[DATA_WIDTH-1:16], wdata_q[15:0]};
                    default: dm_WD = wdata_q;
                endcase
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (write_q) begin
                    rsp_err = 1'b1;
                end else begin
                    case (funct3_q)
                        3'b000:  rsp_rdata = {{(DATA_WIDTH-8){rd_q[7]}}, rd_q[7:0]};
                        3'b001:  rsp_rdata = {{(DATA_WIDTH-16){rd_q[15]}}, rd_q[15:0]};
                        3'b010:  rsp_rdata = rd_q;
                        3'b100:  rsp_rdata = {{(DATA_WIDTH-8){1'b0}}, rd_q[7:0]};
                        3'b101:  rsp_rdata = {{(DATA_WIDTH-16){1'b0}}, rd_q[15:0]};
                        default: rsp_err   = 1'b1;
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-array data_mem model,
// directed vectors, multi-cycle corner sequences and a randomized reference check.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] dm_A;
    logic [31:0] dm_WD;
    logic        dm_WE;
    logic [31:0] dm_RD;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .dm_A(dm_A), .dm_WD(dm_WD), .dm_WE(dm_WE), .dm_RD(dm_RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] PRE0 = 32'h88776655;
    localparam logic [31:0] PRE1 = 32'hCCBBAA99;

    // data_mem environment: 1 KiB byte array, combinational little-endian read.
    logic [7:0] mem [0:1023];
    logic [9:0] memIdx;
    logic       doReload;
    int         weCount;

    assign memIdx = 10'(dm_A % 32'd1024);
    assign dm_RD  = {mem[memIdx + 10'd3], mem[memIdx + 10'd2], mem[memIdx + 10'd1], mem[memIdx]};

    always @(posedge clk) begin
        if (doReload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                mem[256 + i] <= PRE0[8*i +: 8];
                mem[260 + i] <= PRE1[8*i +: 8];
            end
        end else if (dm_WE) begin
            for (int i = 0; i < 4; i++) mem[memIdx + 10'(i)] <= dm_WD[8*i +: 8];
        end
    end

    always @(negedge clk) if (dm_WE === 1'b1) weCount++;

    // Reference memory and behavioural model.
    logic [7:0] refMem [0:1023];
    int checks;
    int failures;

    function automatic logic [31:0] refWord(input logic [31:0] a);
        logic [31:0] w = 0;
        for (int i = 3; i >= 0; i--) w = (w << 8) + 32'(refMem[(a + 32'(i)) % 1024]);
        return w;
    endfunction

    function automatic int storeBytes(input logic [2:0] f3);
        if (f3 == 3'd0) return 1;
        if (f3 == 3'd1) return 2;
        if (f3 == 3'd2) return 4;
        return 0;
    endfunction

    task automatic refLoad(input logic [2:0] f3, input logic [31:0] a,
                           output logic [31:0] data, output bit err);
        logic [31:0] w;
        int b;
        int h;
        w    = refWord(a);
        b    = int'(w % 256);
        h    = int'(w % 65536);
        err  = 1'b0;
        data = 32'd0;
        case (f3)
            3'd0:    data = 32'((b >= 128) ? b - 256 : b);
            3'd1:    data = 32'((h >= 32768) ? h - 65536 : h);
            3'd2:    data = w;
            3'd4:    data = 32'(b);
            3'd5:    data = 32'(h);
            default: err  = 1'b1;
        endcase
    endtask

    task automatic reloadMem();
        for (int i = 0; i < 1024; i++) refMem[i] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            refMem[256 + i] = PRE0[8*i +: 8];
            refMem[260 + i] = PRE1[8*i +: 8];
        end
        doReload = 1'b1;
        @(posedge clk);
        #1 doReload = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One full access from IDLE back to IDLE; call away from the rising edge.
    task automatic applyStimulus(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] expRd,
                                 input bit expErr, input logic [31:0] expWd, input string tag);
        int  weStart;
        bit  expWe;
        expWe      = wr && (storeBytes(f3) != 0);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        #1;
        weStart = weCount;
        checkOutput({tag, "_ready"}, 32'(req_ready), 32'd1);
        checkOutput({tag, "_idleRsp"}, 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput({tag, "_rspValid"}, 32'(rsp_valid), 32'd1);
        checkOutput({tag, "_rdata"}, rsp_rdata, expRd);
        checkOutput({tag, "_err"}, 32'(rsp_err), 32'(expErr));
        checkOutput({tag, "_we"}, 32'(dm_WE), 32'(expWe));
        checkOutput({tag, "_addr"}, dm_A, a);
        checkOutput({tag, "_busy"}, 32'(req_ready), 32'd0);
        if (expWe) checkOutput({tag, "_wd"}, dm_WD, expWd);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput({tag, "_rspDone"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_weCycles"}, 32'(weCount - weStart), 32'(expWe));
    endtask

    typedef struct {
        bit          reload;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRd;
        bit          expErr;
        logic [31:0] expWd;
    } vec_t;

    vec_t vecs [14];

    bit          tpWrite [4];
    logic [31:0] tpData  [4];

    task automatic setTp(input int idx);
        req_valid  = 1'b1;
        req_write  = tpWrite[idx];
        req_funct3 = 3'd2;
        req_addr   = 32'h200;
        req_wdata  = tpData[idx];
    endtask

    initial begin
        logic [31:0] rExp;
        bit          eExp;
        logic [31:0] wExp;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        int          n;

        checks = 0; failures = 0; weCount = 0; doReload = 1'b0;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;

        vecs[0]  = '{1, 0, 3'd0, 32'h103, 32'h0,        32'hFFFFFF88, 0, 32'h0};
        vecs[1]  = '{0, 0, 3'd4, 32'h103, 32'h0,        32'h00000088, 0, 32'h0};
        vecs[2]  = '{0, 0, 3'd2, 32'h102, 32'h0,        32'hAA998877, 0, 32'h0};
        vecs[3]  = '{0, 1, 3'd0, 32'h101, 32'h123456EE, 32'h0,        0, 32'h998877EE};
        vecs[4]  = '{0, 0, 3'd2, 32'h100, 32'h0,        32'h8877EE55, 0, 32'h0};
        vecs[5]  = '{0, 0, 3'd2, 32'h104, 32'h0,        32'hCCBBAA99, 0, 32'h0};
        vecs[6]  = '{1, 1, 3'd1, 32'h102, 32'h0000ABCD, 32'h0,        0, 32'hAA99ABCD};
        vecs[7]  = '{0, 0, 3'd2, 32'h100, 32'h0,        32'hABCD6655, 0, 32'h0};
        vecs[8]  = '{0, 0, 3'd1, 32'h102, 32'h0,        32'hFFFFABCD, 0, 32'h0};
        vecs[9]  = '{0, 0, 3'd5, 32'h102, 32'h0,        32'h0000ABCD, 0, 32'h0};
        vecs[10] = '{1, 1, 3'd3, 32'h100, 32'hFFFFFFFF, 32'h0,        1, 32'h0};
        vecs[11] = '{0, 0, 3'd2, 32'h100, 32'h0,        32'h88776655, 0, 32'h0};
        vecs[12] = '{0, 0, 3'd6, 32'h100, 32'h0,        32'h0,        1, 32'h0};
        vecs[13] = '{0, 0, 3'd7, 32'h104, 32'h0,        32'h0,        1, 32'h0};

        tpWrite = '{1, 0, 1, 0};
        tpData  = '{32'h11111111, 32'h0, 32'h22222222, 32'h0};

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rspValid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rdata", rsp_rdata, 32'd0);
        checkOutput("rst_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_we", 32'(dm_WE), 32'd0);
        checkOutput("rst_wd", dm_WD, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rel_ready", 32'(req_ready), 32'd1);

        // Directed vectors.
        foreach (vecs[i]) begin
            if (vecs[i].reload) begin
                reloadMem();
                @(negedge clk);
                #1;
            end
            applyStimulus(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                          vecs[i].expRd, vecs[i].expErr, vecs[i].expWd, $sformatf("vec%0d", i));
        end

        // Back-to-back requests with req_valid held high.
        @(negedge clk);
        setTp(0);
        for (int cyc = 0; cyc < 8; cyc++) begin
            #1;
            checkOutput($sformatf("tput_ready%0d", cyc), 32'(req_ready), 32'(cyc % 2 == 0));
            checkOutput($sformatf("tput_rsp%0d", cyc), 32'(rsp_valid), 32'(cyc % 2 == 1));
            if (cyc == 3) checkOutput("tput_lw1", rsp_rdata, 32'h11111111);
            if (cyc == 7) checkOutput("tput_lw2", rsp_rdata, 32'h22222222);
            if (cyc % 2 == 1) begin
                if (cyc < 7) setTp((cyc + 1) / 2);
                else         req_valid = 1'b0;
            end
            @(negedge clk);
        end

        // Reset pulled in the middle of a WRITE cycle.
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h200; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        checkOutput("mid_weBefore", 32'(dm_WE), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_weDrop", 32'(dm_WE), 32'd0);
        checkOutput("mid_rspDrop", 32'(rsp_valid), 32'd0);
        checkOutput("mid_readyLow", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("mid_relReady", 32'(req_ready), 32'd1);
        checkOutput("mid_relRsp", 32'(rsp_valid), 32'd0);
        applyStimulus(1'b0, 3'd2, 32'h200, 32'h0, 32'h22222222, 1'b0, 32'h0, "mid_lw");

        // Randomized accesses against the reference model.
        reloadMem();
        @(negedge clk);
        #1;
        for (int i = 0; i < 150; i++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom_range(32'h100, 32'h3F8);
            wd = $urandom;
            if (i % 5 == 0) a = 32'h100 + 32'($urandom_range(0, 7));
            wExp = 32'd0;
            rExp = 32'd0;
            eExp = 1'b0;
            if (wr) begin
                n = storeBytes(f3);
                if (n == 0) begin
                    eExp = 1'b1;
                end else begin
                    wExp = refWord(a);
                    for (int k = 0; k < n; k++) begin
                        wExp[8*k +: 8]          = wd[8*k +: 8];
                        refMem[(a + 32'(k)) % 1024] = wd[8*k +: 8];
                    end
                end
            end else begin
                refLoad(f3, a, rExp, eExp);
            end
            applyStimulus(wr, f3, a, wd, rExp, eExp, wExp, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
